// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter for one RAM port.
// RAM control, wait and load outputs are combinational so that a completion
// is seen in the same cycle as the RAM response. Ties alternate through a
// 1-bit last_grant register, and data wins the first tie after reset.
// Optional feature: define MEM_ARBITER_STATS_EN to add icount/dcount
// completion counters (successful ACCESS completions only).

package cpu_types_pkg;
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;
endpackage

module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              iwait,
   output logic              dwait,
   output logic [WORD_W-1:0] iload,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  ramstate_t         ramstate,
   output logic              ram_err
`ifdef MEM_ARBITER_STATS_EN
   ,
   output logic [31:0]       icount,
   output logic [31:0]       dcount
`endif
);

   typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;
   typedef enum logic {GRANT_DATA, GRANT_INSTR} grant_t;

   state_t state;
   grant_t last_grant;

   logic dreq;
   logic ram_done;
   logic dgrant_live;
   logic igrant_live;
   logic d_done;
   logic i_done;

   // A grant is live only while its request is still present and reset is low;
   // gating with RST keeps an abandoned access from showing a completion.
   assign dreq        = dmemREN | dmemWEN;
   assign ram_done    = (ramstate == ACCESS) || (ramstate == ERROR);
   assign dgrant_live = (state == DACC) && dreq && !RST;
   assign igrant_live = (state == IACC) && iREN && !RST;
   assign d_done      = dgrant_live && ram_done;
   assign i_done      = igrant_live && ram_done;

   // RAM steering, stall and load return for whichever side currently owns the RAM.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      iwait    = iREN & ~i_done;
      dwait    = dreq & ~d_done;
      ram_err  = (d_done || i_done) && (ramstate == ERROR);
      if (dgrant_live) begin
         ramaddr  = daddr;
         ramstore = dstore;
         ramWEN   = dmemWEN;
         ramREN   = dmemREN & ~dmemWEN;
         if (ramstate == ACCESS) begin
            dload = ramload;
         end
      end else if (igrant_live) begin
         ramaddr = iaddr;
         ramREN  = 1'b1;
         if (ramstate == ACCESS) begin
            iload = ramload;
         end
      end
   end

   // Grant FSM: choose a side in IDLE, hold until the RAM completes or the
   // request is withdrawn; only real completions move the tie-break pointer.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         last_grant <= GRANT_INSTR;
      end else begin
         case (state)
            IDLE: begin
               if (dreq && iREN) begin
                  state <= (last_grant == GRANT_INSTR) ? DACC : IACC;
               end else if (dreq) begin
                  state <= DACC;
               end else if (iREN) begin
                  state <= IACC;
               end
            end
            DACC: begin
               if (!dreq) begin
                  state <= IDLE;
               end else if (ram_done) begin
                  state      <= IDLE;
                  last_grant <= GRANT_DATA;
               end
            end
            IACC: begin
               if (!iREN) begin
                  state <= IDLE;
               end else if (ram_done) begin
                  state      <= IDLE;
                  last_grant <= GRANT_INSTR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARBITER_STATS_EN
   // Completion counters: successful ACCESS completions only, wrapping naturally.
   always_ff @(posedge CLK) begin
      if (RST) begin
         icount <= '0;
         dcount <= '0;
      end else begin
         if (i_done && (ramstate == ACCESS)) begin
            icount <= icount + 32'd1;
         end
         if (d_done && (ramstate == ACCESS)) begin
            dcount <= dcount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.

module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int WORD_W = 32;

   logic              CLK = 1'b0;
   logic              RST;
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              dmemREN;
   logic              dmemWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              iwait;
   logic              dwait;
   logic [WORD_W-1:0] iload;
   logic [WORD_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   ramstate_t         ramstate;
   logic              ram_err;
`ifdef MEM_ARBITER_STATS_EN
   logic [31:0]       icount;
   logic [31:0]       dcount;
`endif

   int vectors = 0;
   int miscompares = 0;

   mem_arbiter #(.WORD_W(WORD_W)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
`ifdef MEM_ARBITER_STATS_EN
      , .icount(icount), .dcount(dcount)
`endif
   );

   // Free-running 10-unit clock.
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      iREN = 0; dmemREN = 0; dmemWEN = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
   endtask

   task automatic test_reset();
      RST = 1; clear_inputs();
      tick(); tick();
      #1;
      vectors++; if (ramREN !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ramREN: got %b expected 0", ramREN); end
      vectors++; if (ramWEN !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ramWEN: got %b expected 0", ramWEN); end
      vectors++; if (ram_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_err: got %b expected 0", ram_err); end
      vectors++; if ({iwait, dwait} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_waits: got %b expected 00", {iwait, dwait}); end
      vectors++; if ({iload, dload} !== '0) begin miscompares++; $display("[TB] FAIL reset_loads: got %h/%h expected 0/0", iload, dload); end
`ifdef MEM_ARBITER_STATS_EN
      vectors++; if ({icount, dcount} !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", icount, dcount); end
`endif
      RST = 0;
      tick();
   endtask

   task automatic test_data_read();
      dmemREN = 1; daddr = 32'h40;
      #1;
      vectors++; if ({dwait, ramREN, iwait} !== 3'b100) begin miscompares++; $display("[TB] FAIL dread_idle: got dwait/ramREN/iwait=%b expected 100", {dwait, ramREN, iwait}); end
      tick();
      ramstate = ACCESS; ramload = 32'h1234;
      #1;
      vectors++; if (ramaddr !== 32'h40) begin miscompares++; $display("[TB] FAIL dread_addr: got %h expected 00000040", ramaddr); end
      vectors++; if (ramREN !== 1'b1) begin miscompares++; $display("[TB] FAIL dread_ramREN: got %b expected 1", ramREN); end
      vectors++; if (dload !== 32'h1234) begin miscompares++; $display("[TB] FAIL dread_dload: got %h expected 00001234", dload); end
      vectors++; if ({dwait, iwait} !== 2'b00) begin miscompares++; $display("[TB] FAIL dread_waits: got %b expected 00", {dwait, iwait}); end
      tick();
      clear_inputs();
      #1;
      vectors++; if ({dload, ramREN} !== '0) begin miscompares++; $display("[TB] FAIL dread_after: got dload=%h ramREN=%b expected 0/0", dload, ramREN); end
   endtask

   task automatic test_alternation();
      RST = 1; tick(); RST = 0;
      iREN = 1; dmemREN = 1; iaddr = 32'h100; daddr = 32'h200;
      tick();
      #1;
      vectors++; if (ramaddr !== 32'h200) begin miscompares++; $display("[TB] FAIL alt_first_data: got %h expected 00000200", ramaddr); end
      vectors++; if ({iwait, dwait} !== 2'b11) begin miscompares++; $display("[TB] FAIL alt_free_waits: got %b expected 11", {iwait, dwait}); end
      ramstate = ACCESS; ramload = 32'hAAAA;
      #1;
      vectors++; if ({iwait, dwait, dload, iload} !== {2'b10, 32'hAAAA, 32'h0}) begin miscompares++; $display("[TB] FAIL alt_dcomplete: got waits=%b dload=%h iload=%h expected 10/0000aaaa/0", {iwait, dwait}, dload, iload); end
      tick();
      ramstate = FREE;
      #1;
      vectors++; if ({ramREN, iwait, dwait} !== 3'b011) begin miscompares++; $display("[TB] FAIL alt_idle: got ramREN/iwait/dwait=%b expected 011", {ramREN, iwait, dwait}); end
      tick();
      #1;
      vectors++; if ({ramaddr, ramREN, ramWEN} !== {32'h100, 2'b10}) begin miscompares++; $display("[TB] FAIL alt_second_instr: got addr=%h REN/WEN=%b expected 00000100/10", ramaddr, {ramREN, ramWEN}); end
      ramstate = ACCESS; ramload = 32'hBBBB;
      #1;
      vectors++; if ({iwait, dwait, iload, dload} !== {2'b01, 32'hBBBB, 32'h0}) begin miscompares++; $display("[TB] FAIL alt_icomplete: got waits=%b iload=%h dload=%h expected 01/0000bbbb/0", {iwait, dwait}, iload, dload); end
      tick();
      ramstate = FREE;
      tick();
      #1;
      vectors++; if (ramaddr !== 32'h200) begin miscompares++; $display("[TB] FAIL alt_third_data: got %h expected 00000200", ramaddr); end
      ramstate = ACCESS;
      tick();
`ifdef MEM_ARBITER_STATS_EN
      vectors++; if ({icount, dcount} !== {32'd1, 32'd2}) begin miscompares++; $display("[TB] FAIL alt_counts: got %0d/%0d expected 1/2", icount, dcount); end
`endif
      clear_inputs();
      tick();
   endtask

   task automatic test_write();
      dmemREN = 1; dmemWEN = 1; dstore = 32'hCAFE; daddr = 32'h80;
      tick();
      #1;
      vectors++; if ({ramWEN, ramREN} !== 2'b10) begin miscompares++; $display("[TB] FAIL write_strobes: got WEN/REN=%b expected 10", {ramWEN, ramREN}); end
      vectors++; if ({ramstore, ramaddr} !== {32'hCAFE, 32'h80}) begin miscompares++; $display("[TB] FAIL write_bus: got store=%h addr=%h expected 0000cafe/00000080", ramstore, ramaddr); end
      ramstate = ACCESS;
      #1;
      vectors++; if (dwait !== 1'b0) begin miscompares++; $display("[TB] FAIL write_done: got dwait=%b expected 0", dwait); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_busy();
      dmemREN = 1; daddr = 32'h10;
      tick();
      ramstate = BUSY;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++; if ({dwait, dload} !== {1'b1, 32'h0}) begin miscompares++; $display("[TB] FAIL busy_cycle%0d: got dwait=%b dload=%h expected 1/0", c, dwait, dload); end
         tick();
      end
      ramstate = ACCESS; ramload = 32'h77;
      #1;
      vectors++; if ({dwait, dload} !== {1'b0, 32'h77}) begin miscompares++; $display("[TB] FAIL busy_complete: got dwait=%b dload=%h expected 0/00000077", dwait, dload); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_error();
      iREN = 1; iaddr = 32'h300;
      tick();
      ramstate = ERROR; ramload = 32'hDEAD;
      #1;
      vectors++; if ({ram_err, iwait, iload} !== {2'b10, 32'h0}) begin miscompares++; $display("[TB] FAIL err_complete: got ram_err/iwait=%b iload=%h expected 10/0", {ram_err, iwait}, iload); end
      tick();
      ramstate = ACCESS;
      #1;
      vectors++; if ({ram_err, ramREN, iwait, iload} !== {3'b001, 32'h0}) begin miscompares++; $display("[TB] FAIL err_back_idle: got err/REN/iwait=%b iload=%h expected 001/0", {ram_err, ramREN, iwait}, iload); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      dmemREN = 1; daddr = 32'h44;
      tick();
      ramstate = BUSY;
      #1;
      vectors++; if (ramREN !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_granted: got ramREN=%b expected 1", ramREN); end
      RST = 1; ramstate = ACCESS; ramload = 32'h99;
      #1;
      vectors++; if ({ramREN, ram_err, dwait, dload} !== {3'b001, 32'h0}) begin miscompares++; $display("[TB] FAIL rstmid_abandon: got REN/err/dwait=%b dload=%h expected 001/0", {ramREN, ram_err, dwait}, dload); end
      tick();
      RST = 0;
      #1;
      vectors++; if ({ramREN, dwait, dload} !== {2'b01, 32'h0}) begin miscompares++; $display("[TB] FAIL rstmid_idle: got REN/dwait=%b dload=%h expected 01/0", {ramREN, dwait}, dload); end
`ifdef MEM_ARBITER_STATS_EN
      vectors++; if (dcount !== 32'd0) begin miscompares++; $display("[TB] FAIL rstmid_dcount: got %0d expected 0", dcount); end
`endif
      clear_inputs();
      tick();
   endtask

   task automatic test_withdraw();
      dmemREN = 1; daddr = 32'h60; iaddr = 32'h500;
      tick();
      dmemREN = 0; ramstate = ACCESS; ramload = 32'h11;
      #1;
      vectors++; if ({ramREN, ramWEN, dwait, dload} !== {3'b000, 32'h0}) begin miscompares++; $display("[TB] FAIL withdraw_strobes: got REN/WEN/dwait=%b dload=%h expected 000/0", {ramREN, ramWEN, dwait}, dload); end
      tick();
      ramstate = FREE; dmemREN = 1; iREN = 1;
      tick();
      #1;
      vectors++; if (ramaddr !== 32'h60) begin miscompares++; $display("[TB] FAIL withdraw_tiebreak: got %h expected 00000060", ramaddr); end
      ramstate = ACCESS;
      tick();
      clear_inputs();
      tick();
   endtask

   // Scenario sequence; every scenario starts and ends with the arbiter idle.
   initial begin
      test_reset();
      test_data_read();
      test_alternation();
      test_write();
      test_busy();
      test_error();
      test_reset_mid();
      test_withdraw();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, RAM address/data width in bits.
REQ-002 SHALL have port CLK  input  1  rising-edge clock, sole clock of the block.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port iREN  input  1  instruction fetch request.
REQ-005 SHALL have port iaddr  input  WORD_W  instruction address.
REQ-006 SHALL have ports dmemREN and dmemWEN, each input 1, data read/write request driven by the request unit.
REQ-007 SHALL have ports daddr and dstore, each input WORD_W, data address and store data.
REQ-008 SHALL have ports iwait and dwait, each output 1, high while the requester must stall.
REQ-009 SHALL have ports iload and dload, each output WORD_W, returned read data.
REQ-010 SHALL have ports ramREN and ramWEN (output 1), ramaddr and ramstore (output WORD_W), ramload (input WORD_W), and ramstate (input, ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR).
REQ-011 SHALL have port ram_err  output  1  single-cycle pulse on an ERROR completion.

Function
REQ-012 SHALL implement an FSM with states IDLE, DACC and IACC, plus a 1-bit last_grant register (DATA/INSTR).
REQ-013 In IDLE, with only a data request (dmemREN|dmemWEN) pending, SHALL go to DACC next cycle; with only iREN pending, SHALL go to IACC.
REQ-014 In IDLE, with both pending, SHALL grant the side opposite last_grant.
REQ-015 In IDLE, SHALL drive ramREN=ramWEN=0 and iwait=dwait=1 whenever the corresponding request is high.
REQ-016 In DACC, SHALL drive ramaddr=daddr and ramstore=dstore combinationally; ramWEN=dmemWEN; ramREN=dmemREN & ~dmemWEN (write wins when both are high).
REQ-017 In IACC, SHALL drive ramaddr=iaddr, ramREN=1 and ramWEN=0.
REQ-018 When ramstate==ACCESS in DACC/IACC, SHALL in that same cycle drop the granted wait, drive the granted load from ramload, update last_grant, and return to IDLE next cycle.
REQ-019 When ramstate==ERROR in a grant state, SHALL complete as for ACCESS but with load=0 and ram_err=1 for that cycle.
REQ-020 While ramstate is BUSY or FREE in a grant state, SHALL hold state and keep the granted wait high.
REQ-021 If the granted request is withdrawn mid-access (DACC with dmemREN=dmemWEN=0, or IACC with iREN=0), SHALL deassert RAM strobes that cycle and return to IDLE without updating last_grant.
REQ-022 The non-granted side's wait SHALL stay high while its request is high; an idle side's wait SHALL be 0.
REQ-023 iload/dload SHALL be 0 except in the completion cycle of their own side.
REQ-024 Minimum latency SHALL be 2 cycles: request seen in IDLE at cycle N, completion at N+1 when ramstate==ACCESS.

Reset
REQ-025 With RST high at a CLK edge, SHALL set state=IDLE and last_grant=INSTR (data wins the first tie), clear counters, and force all RAM strobes, ram_err and loads to 0.
REQ-026 RST asserted mid-access SHALL abandon the access; no completion or ram_err SHALL be produced.

Configuration
REQ-027 With macro MEM_ARBITER_STATS_EN defined, SHALL add outputs icount and dcount (32 bits each), incremented on each ACCESS completion of the side, wrapping 0xFFFFFFFF->0, not counting ERROR or withdrawn accesses.
REQ-028 Without MEM_ARBITER_STATS_EN, those ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-029 Data read alone, daddr=0x40, ramstate ACCESS on 2nd cycle, ramload=0x1234 -> dload=0x1234, dwait low one cycle, iwait=0.
REQ-030 iREN and dmemREN together after reset -> DACC first; after it completes -> IACC; then tie again -> DACC (alternation).
REQ-031 dmemREN=dmemWEN=1, dstore=0xCAFE -> ramWEN=1, ramREN=0, ramstore=0xCAFE.
REQ-032 ramstate BUSY for 3 cycles then ACCESS -> dwait high 3 cycles, completion on 4th.
REQ-033 ramstate ERROR during IACC -> iload=0, ram_err pulse of 1 cycle, FSM returns to IDLE.
REQ-034 RST during DACC, then release -> IDLE, no dwait drop, with stats enabled dcount=0.
